// File: rtl/emergency_preempt.sv
// ---------------------------------------------------------------------------
// emergency_preempt
//   Emergency-vehicle preemption sequencer placed between the normal phase
//   controller and the lamp drivers. While idle it passes the normal light
//   codes through with one cycle of latency. On an emergency request it
//   clears conflicting lanes (yellow, then all-red), grants green to the
//   requesting lane for at least HOLD_CYC cycles (longer while the request
//   stays high), then runs an exit clearance and hands control back.
//
//   Lane light code, 2 bits per lane (lane i = bits [2i+1:2i]):
//     00 RED, 01 YELLOW, 11 GREEN, 10 treated as RED.
//
// Ports
//   clk           in   1          rising-edge clock
//   rst           in   1          synchronous reset, active high
//   emergencyLane in   LANES      level request per lane, lane 0 = highest priority
//   normalLane    in   2*LANES    light codes from the normal controller
//   laneOutput    out  2*LANES    registered light codes to the lamp drivers
//   preemptActive out  1          registered, high whenever not IDLE
//   servedLane    out  SL_W       registered index of the lane being served
//
// Configuration
//   EMERGENCY_PREEMPT_CHAIN_EN  when defined, a request pending at the end of
//   the exit all-red interval is granted directly (lanes are already red),
//   without returning through IDLE and a fresh clearance sequence.
// ---------------------------------------------------------------------------

// Per-lane light code selection for the state being entered.
module emergency_preempt_lane (
    input  logic       pass_i,    // pass the normal code through
    input  logic       grn_i,     // this lane shows GREEN
    input  logic       yel_i,     // this lane shows YELLOW
    input  logic [1:0] normal_i,  // normal-controller code for this lane
    output logic [1:0] code_o,    // code to register for the lamp driver
    output logic       green_o    // normal code is GREEN (10 is not green)
);
    assign green_o = (normal_i == 2'b11);

    always_comb begin
        if (pass_i)     code_o = normal_i;
        else if (grn_i) code_o = 2'b11;
        else if (yel_i) code_o = 2'b01;
        else            code_o = 2'b00;
    end
endmodule

module emergency_preempt #(
    parameter  int LANES      = 4,
    parameter  int YELLOW_CYC = 8,
    parameter  int ALLRED_CYC = 4,
    parameter  int HOLD_CYC   = 16,
    parameter  int CNT_W      = 8,
    localparam int SL_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     emergencyLane,
    input  logic [2*LANES-1:0]   normalLane,
    output logic [2*LANES-1:0]   laneOutput,
    output logic                 preemptActive,
    output logic [SL_W-1:0]      servedLane
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLR_YEL  = 3'd1,
        CLR_RED  = 3'd2,
        GRANT    = 3'd3,
        EXIT_YEL = 3'd4,
        EXIT_RED = 3'd5
    } state_t;

    // Counter load values: a state lasting N cycles loads N-1 on entry and
    // exits on the edge where the counter reads 0.
    localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SL_W-1:0]        served_q, served_d;
    logic [LANES-1:0]       ymask_q, ymask_d;   // lanes green at capture
    logic [2*LANES-1:0]     lane_q, lane_d;
    logic                   active_q, active_d;

    logic [LANES-1:0]       green_now;
    logic [LANES-1:0][1:0]  lane_code_d;
    logic                   cnt_zero;

    // Fixed priority: lowest set index wins.
    function automatic logic [SL_W-1:0] lowest(input logic [LANES-1:0] v);
        lowest = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest = SL_W'(i);
        end
    endfunction

    assign cnt_zero = (cnt_q == '0);

    // ---------------- next-state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        served_d = served_q;
        ymask_d  = ymask_q;

        case (state_q)
            IDLE: begin
                if (|emergencyLane) begin
                    served_d = lowest(emergencyLane);
                    ymask_d  = green_now;
                    // Nothing green means nothing to clear through yellow.
                    if (|green_now) begin
                        state_d = CLR_YEL;
                        cnt_d   = YEL_LD;
                    end else begin
                        state_d = CLR_RED;
                        cnt_d   = RED_LD;
                    end
                end
            end
            CLR_YEL: begin
                if (cnt_zero) begin
                    state_d = CLR_RED;
                    cnt_d   = RED_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CLR_RED: begin
                if (cnt_zero) begin
                    state_d = GRANT;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GRANT: begin
                // Minimum hold first; afterwards the request level extends it.
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!emergencyLane[served_q]) begin
                    state_d = EXIT_YEL;
                    cnt_d   = YEL_LD;
                end
            end
            EXIT_YEL: begin
                if (cnt_zero) begin
                    state_d = EXIT_RED;
                    cnt_d   = RED_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EXIT_RED: begin
                if (cnt_zero) begin
`ifdef EMERGENCY_PREEMPT_CHAIN_EN
                    if (|emergencyLane) begin
                        state_d  = GRANT;
                        served_d = lowest(emergencyLane);
                        cnt_d    = HOLD_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- per-lane output codes for the state being entered ----
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic is_served;
        logic pass, grn, yel;

        assign is_served = (served_d == SL_W'(g));
        assign pass      = (state_d == IDLE);
        assign grn       = (state_d == GRANT) && is_served;
        assign yel       = ((state_d == CLR_YEL) && ymask_d[g]) ||
                           ((state_d == EXIT_YEL) && is_served);

        emergency_preempt_lane u_lane (
            .pass_i   (pass),
            .grn_i    (grn),
            .yel_i    (yel),
            .normal_i (normalLane[2*g +: 2]),
            .code_o   (lane_code_d[g]),
            .green_o  (green_now[g])
        );
    end

    assign lane_d   = lane_code_d;
    assign active_d = (state_d != IDLE);

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            served_q <= '0;
            ymask_q  <= '0;
            lane_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            ymask_q  <= ymask_d;
            lane_q   <= lane_d;
            active_q <= active_d;
        end
    end

    assign laneOutput    = lane_q;
    assign preemptActive = active_q;
    assign servedLane    = served_q;

endmodule
